// File: rtl/fir_serial_mac_mc_if.sv
// Sample, coefficient and result bus of fir_serial_mac_mc.
// master : the side that offers samples/coefficients and takes results.
// slave  : the filter.
//   in_valid/in_ready/in_data/in_chan  sample handshake
//   coef_wr/coef_addr/coef_data        coefficient write port
//   out_valid/out_data/out_chan        one-cycle result strobe, held data
interface fir_serial_mac_mc_if #(
    parameter int unsigned DATA_IN_WIDTH  = 16,
    parameter int unsigned DATA_OUT_WIDTH = 64,
    parameter int unsigned TAP_WIDTH      = 32,
    parameter int unsigned TAP_COUNT      = 34,
    parameter int unsigned CHANNELS       = 4
);
    localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned AW = $clog2(TAP_COUNT);

    logic                             in_valid;
    logic                             in_ready;
    logic signed [DATA_IN_WIDTH-1:0]  in_data;
    logic        [CW-1:0]             in_chan;
    logic                             coef_wr;
    logic        [AW-1:0]             coef_addr;
    logic signed [TAP_WIDTH-1:0]      coef_data;
    logic                             out_valid;
    logic signed [DATA_OUT_WIDTH-1:0] out_data;
    logic        [CW-1:0]             out_chan;

    modport master (
        output in_valid, in_data, in_chan, coef_wr, coef_addr, coef_data,
        input  in_ready, out_valid, out_data, out_chan
    );

    modport slave (
        input  in_valid, in_data, in_chan, coef_wr, coef_addr, coef_data,
        output in_ready, out_valid, out_data, out_chan
    );
endinterface

// File: rtl/fir_serial_mac_mc.sv
// Multi-channel FIR filter with a single serial multiplier.
// Each accepted sample shifts its channel's delay line, then TAP_COUNT MAC cycles
// accumulate d[c][k] * coef[k]; the result is strobed on out_valid for one cycle.
// All channels share one writable coefficient bank (reset to TAPS).
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    fir_serial_mac_mc_if.slave (sample handshake, coefficient writes, results)
// Optional feature: define FIR_SATURATE_EN to clamp the result to the signed
// DATA_OUT_WIDTH range instead of truncating it.
module fir_serial_mac_mc #(
    parameter int unsigned DATA_IN_WIDTH  = 16,
    parameter int unsigned DATA_OUT_WIDTH = 64,
    parameter int unsigned TAP_WIDTH      = 32,
    parameter int unsigned TAP_COUNT      = 34,
    parameter int unsigned CHANNELS       = 4,
    parameter logic signed [TAP_WIDTH-1:0] TAPS [TAP_COUNT] = '{default: '0}
) (
    input logic               clk,
    input logic               reset,
    fir_serial_mac_mc_if.slave bus
);
    localparam int unsigned CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned AW    = $clog2(TAP_COUNT);
    localparam int unsigned PW    = DATA_IN_WIDTH + TAP_WIDTH;
    localparam int unsigned ACC_W = DATA_IN_WIDTH + TAP_WIDTH + AW;

    localparam logic [CW:0]   CHAN_LIM = (CW + 1)'(CHANNELS);
    localparam logic [AW:0]   TAP_LIM  = (AW + 1)'(TAP_COUNT);
    localparam logic [AW-1:0] K_LAST   = AW'(TAP_COUNT - 1);

    typedef enum logic [0:0] {StIdle, StMac} state_e;

    state_e state_q, state_d;
    logic   in_ready;
    logic   accept;
    logic   coef_we;
    logic   last_tap;

    logic signed [DATA_IN_WIDTH-1:0]  dly_q [CHANNELS][TAP_COUNT];
    logic signed [TAP_WIDTH-1:0]      coef_q [TAP_COUNT];
    logic signed [ACC_W-1:0]          acc_q;
    logic        [AW-1:0]             k_q;
    logic        [CW-1:0]             chan_q;
    logic                             out_valid_q;
    logic signed [DATA_OUT_WIDTH-1:0] out_data_q;
    logic        [CW-1:0]             out_chan_q;

    logic signed [DATA_IN_WIDTH-1:0]  d_sel;
    logic signed [TAP_WIDTH-1:0]      c_sel;
    logic signed [PW-1:0]             prod;
    logic signed [ACC_W-1:0]          acc_sum;
    logic signed [DATA_OUT_WIDTH-1:0] result;

    // Out-of-range channels are consumed in IDLE but never start a MAC pass.
    assign accept   = bus.in_valid && in_ready && ({1'b0, bus.in_chan} < CHAN_LIM);
    assign coef_we  = bus.coef_wr && in_ready && ({1'b0, bus.coef_addr} < TAP_LIM);
    assign last_tap = (state_q == StMac) && (k_q == K_LAST);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StMac;
            StMac:   if (last_tap) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready = (state_q == StIdle);
    end

    // ---------------- datapath ----------------
    assign d_sel   = dly_q[chan_q][k_q];
    assign c_sel   = coef_q[k_q];
    assign prod    = d_sel * c_sel;
    assign acc_sum = acc_q + ACC_W'(prod);

    if (DATA_OUT_WIDTH >= ACC_W) begin : g_wide
        assign result = DATA_OUT_WIDTH'(acc_sum);
    end else begin : g_narrow
`ifdef FIR_SATURATE_EN
        // The value fits iff every bit from the output sign bit upward agrees.
        localparam int unsigned HI = ACC_W - DATA_OUT_WIDTH + 1;
        localparam logic signed [DATA_OUT_WIDTH-1:0] MAX_V = {1'b0, {(DATA_OUT_WIDTH-1){1'b1}}};
        localparam logic signed [DATA_OUT_WIDTH-1:0] MIN_V = {1'b1, {(DATA_OUT_WIDTH-1){1'b0}}};
        logic [HI-1:0] top;
        assign top = acc_sum[ACC_W-1 -: HI];
        always_comb begin
            if ((&top) || !(|top)) begin
                result = acc_sum[DATA_OUT_WIDTH-1:0];
            end else if (acc_sum[ACC_W-1]) begin
                result = MIN_V;
            end else begin
                result = MAX_V;
            end
        end
`else
        assign result = acc_sum[DATA_OUT_WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                for (int unsigned k = 0; k < TAP_COUNT; k++) begin
                    dly_q[c][k] <= '0;
                end
            end
            for (int unsigned k = 0; k < TAP_COUNT; k++) begin
                coef_q[k] <= TAPS[k];
            end
            acc_q       <= '0;
            k_q         <= '0;
            chan_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
        end else begin
            out_valid_q <= 1'b0;
            // Coefficients are only read in MAC, so a write on the accept edge
            // is already visible to that sample.
            if (coef_we) begin
                coef_q[bus.coef_addr] <= bus.coef_data;
            end
            if (accept) begin
                dly_q[bus.in_chan][0] <= bus.in_data;
                for (int unsigned k = 1; k < TAP_COUNT; k++) begin
                    dly_q[bus.in_chan][k] <= dly_q[bus.in_chan][k-1];
                end
                acc_q  <= '0;
                k_q    <= '0;
                chan_q <= bus.in_chan;
            end else if (state_q == StMac) begin
                acc_q <= acc_sum;
                k_q   <= k_q + AW'(1);
                if (last_tap) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= result;
                    out_chan_q  <= chan_q;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;

endmodule

// File: tb/tb_fir_serial_mac_mc.sv
// Self-checking bench for fir_serial_mac_mc: a vector table of single samples,
// hand-written multi-cycle sequences, randomized traffic, and a narrow-output
// instance for the FIR_SATURATE_EN behaviour. Every cycle the DUT is compared
// against a sample-level reference model.
module tb_fir_serial_mac_mc;
    localparam int unsigned TC  = 4;
    localparam int unsigned CH  = 3;
    localparam int unsigned DIW = 16;
    localparam int unsigned DOW = 64;
    localparam int unsigned TW  = 32;
    localparam int unsigned CWM = 2;
    localparam int unsigned AWM = 2;

    localparam logic signed [TW-1:0] TAPS_M [TC] = '{32'sd1, 32'sd2, 32'sd3, 32'sd4};
    localparam logic signed [15:0]   TAPS_S [TC] = '{16'sd32767, 16'sd0, 16'sd0, 16'sd0};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fir_serial_mac_mc_if #(
        .DATA_IN_WIDTH(DIW), .DATA_OUT_WIDTH(DOW), .TAP_WIDTH(TW),
        .TAP_COUNT(TC), .CHANNELS(CH)
    ) m_if ();

    fir_serial_mac_mc #(
        .DATA_IN_WIDTH(DIW), .DATA_OUT_WIDTH(DOW), .TAP_WIDTH(TW),
        .TAP_COUNT(TC), .CHANNELS(CH), .TAPS(TAPS_M)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(m_if)
    );

    fir_serial_mac_mc_if #(
        .DATA_IN_WIDTH(16), .DATA_OUT_WIDTH(16), .TAP_WIDTH(16),
        .TAP_COUNT(TC), .CHANNELS(1)
    ) s_if ();

    fir_serial_mac_mc #(
        .DATA_IN_WIDTH(16), .DATA_OUT_WIDTH(16), .TAP_WIDTH(16),
        .TAP_COUNT(TC), .CHANNELS(1), .TAPS(TAPS_S)
    ) dut_sat (
        .clk(clk),
        .reset(reset),
        .bus(s_if)
    );

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: per-channel sample history, coefficient bank, pending result.
    logic signed [DIW-1:0] hist [CH][TC];
    logic signed [TW-1:0]  coef_m [TC];
    bit     ready_m;
    int     due;
    longint pend;
    int     pend_chan;
    bit     exp_valid;
    longint exp_data;
    int     exp_chan;
    int     n_acc = 0;

    typedef struct {
        bit     rst;
        int     chan;
        int     data;
        bit     cwr;
        int     caddr;
        int     cdata;
        longint exp_d;
    } vec_t;

    vec_t vecs [9];

    function automatic void chk(string name, logic signed [63:0] act, logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < int'(CH); c++) begin
            for (int k = 0; k < int'(TC); k++) hist[c][k] = '0;
        end
        for (int k = 0; k < int'(TC); k++) coef_m[k] = TAPS_M[k];
        ready_m   = 1'b1;
        due       = 0;
        exp_valid = 1'b0;
        exp_data  = 0;
        exp_chan  = 0;
    endfunction

    task automatic drive_idle();
        m_if.in_valid  = 1'b0;
        m_if.in_data   = '0;
        m_if.in_chan   = '0;
        m_if.coef_wr   = 1'b0;
        m_if.coef_addr = '0;
        m_if.coef_data = '0;
    endtask

    // Advance the model by one edge using the inputs currently driven, then
    // clock the DUT and compare every output.
    task automatic tick();
        int c;
        if (reset) begin
            model_reset();
        end else begin
            exp_valid = 1'b0;
            if (ready_m) begin
                if (m_if.coef_wr && int'(m_if.coef_addr) < int'(TC))
                    coef_m[m_if.coef_addr] = m_if.coef_data;
                if (m_if.in_valid && int'(m_if.in_chan) < int'(CH)) begin
                    c = int'(m_if.in_chan);
                    for (int k = int'(TC) - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
                    hist[c][0] = m_if.in_data;
                    pend = 0;
                    for (int k = 0; k < int'(TC); k++)
                        pend += longint'(hist[c][k]) * longint'(coef_m[k]);
                    pend_chan = c;
                    due       = int'(TC);
                    ready_m   = 1'b0;
                    n_acc++;
                end
            end else begin
                due--;
                if (due == 0) begin
                    exp_valid = 1'b1;
                    exp_data  = pend;
                    exp_chan  = pend_chan;
                    ready_m   = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("in_ready", 64'(m_if.in_ready), 64'(ready_m));
        chk("out_valid", 64'(m_if.out_valid), 64'(exp_valid));
        chk("out_data", 64'($signed(m_if.out_data)), exp_data);
        chk("out_chan", 64'(m_if.out_chan), 64'(exp_chan));
    endtask

    // Offer one sample (optionally with a coefficient write), then wait out the
    // MAC pass and compare against a hand-derived constant.
    task automatic send_check(string name, int chan, int data, bit cwr, int caddr, int cdata,
                              longint exp_d);
        m_if.in_valid  = 1'b1;
        m_if.in_chan   = CWM'(chan);
        m_if.in_data   = DIW'(data);
        m_if.coef_wr   = cwr;
        m_if.coef_addr = AWM'(caddr);
        m_if.coef_data = TW'(cdata);
        tick();
        drive_idle();
        for (int i = 0; i < int'(TC); i++) tick();
        chk({name, "_valid"}, 64'(m_if.out_valid), 64'd1);
        chk(name, 64'($signed(m_if.out_data)), exp_d);
        chk({name, "_chan"}, 64'(m_if.out_chan), 64'(chan));
    endtask

    initial begin
        int n0;
        longint sat_exp;

        vecs[0] = '{1'b1, 0, 3, 1'b1, 0, -1, -3};  // coef write on the accept edge
        vecs[1] = '{1'b1, 0, 1, 1'b0, 0, 0, 1};    // impulse
        vecs[2] = '{1'b0, 0, 0, 1'b0, 0, 0, 2};
        vecs[3] = '{1'b0, 0, 0, 1'b0, 0, 0, 3};
        vecs[4] = '{1'b0, 0, 0, 1'b0, 0, 0, 4};
        vecs[5] = '{1'b0, 0, 5, 1'b0, 0, 0, 5};    // channel isolation
        vecs[6] = '{1'b0, 1, 7, 1'b0, 0, 0, 7};
        vecs[7] = '{1'b0, 0, 0, 1'b0, 0, 0, 10};
        vecs[8] = '{1'b0, 2, -2, 1'b0, 0, 0, -2};

        drive_idle();
        s_if.in_valid  = 1'b0;
        s_if.in_data   = '0;
        s_if.in_chan   = '0;
        s_if.coef_wr   = 1'b0;
        s_if.coef_addr = '0;
        s_if.coef_data = '0;
        model_reset();

        reset = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", 64'(m_if.in_ready), 64'd1);
        chk("rst_out_valid", 64'(m_if.out_valid), 64'd0);
        chk("rst_out_data", 64'($signed(m_if.out_data)), 64'sd0);
        chk("rst_out_chan", 64'(m_if.out_chan), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].rst) begin
                reset = 1'b1;
                tick();
                tick();
                reset = 1'b0;
            end
            send_check($sformatf("vec%0d", i), vecs[i].chan, vecs[i].data, vecs[i].cwr,
                       vecs[i].caddr, vecs[i].cdata, vecs[i].exp_d);
        end

        // Coefficient write while busy must be dropped: ch1 history becomes 1,7 then 2,1,7.
        m_if.in_valid = 1'b1;
        m_if.in_chan  = CWM'(1);
        m_if.in_data  = DIW'(1);
        tick();
        drive_idle();
        m_if.coef_wr   = 1'b1;
        m_if.coef_addr = AWM'(0);
        m_if.coef_data = TW'(100);
        tick();
        tick();
        drive_idle();
        tick();
        tick();
        chk("mac_wr_first", 64'($signed(m_if.out_data)), 64'sd15);
        send_check("mac_wr_ignored", 1, 2, 1'b0, 0, 0, 25);

        // Out-of-range channel: consumed, no pass, no history change.
        n0 = n_acc;
        m_if.in_valid = 1'b1;
        m_if.in_chan  = CWM'(3);
        m_if.in_data  = DIW'(99);
        tick();
        drive_idle();
        for (int i = 0; i < 5; i++) tick();
        chk("bad_chan_accepts", 64'(n_acc - n0), 64'd0);
        send_check("bad_chan_hist", 0, 0, 1'b0, 0, 0, 15);

        // Backpressure: in_valid held for 20 cycles.
        n0 = n_acc;
        m_if.in_valid = 1'b1;
        m_if.in_chan  = CWM'(0);
        for (int i = 0; i < 20; i++) begin
            m_if.in_data = DIW'(100 + i);
            tick();
        end
        drive_idle();
        for (int i = 0; i < 5; i++) tick();
        chk("bp_accepts", 64'(n_acc - n0), 64'd4);

        // Reset two cycles into a pass: no strobe, then a clean impulse.
        m_if.in_valid = 1'b1;
        m_if.in_chan  = CWM'(0);
        m_if.in_data  = DIW'(9);
        tick();
        drive_idle();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        send_check("rst_abort_impulse", 0, 1, 1'b0, 0, 0, 1);

        // Randomized traffic, including invalid channels and stray coefficient writes.
        for (int i = 0; i < 400; i++) begin
            m_if.in_valid  = 1'($urandom_range(0, 1));
            m_if.in_chan   = CWM'($urandom_range(0, 3));
            m_if.in_data   = DIW'($urandom);
            m_if.coef_wr   = ($urandom_range(0, 7) == 0);
            m_if.coef_addr = AWM'($urandom_range(0, 3));
            m_if.coef_data = TW'($urandom);
            tick();
        end
        drive_idle();
        for (int i = 0; i < 6; i++) tick();

        // Narrow output: 32767 * 32767 = 0x3FFF0001.
`ifdef FIR_SATURATE_EN
        sat_exp = 32767;
`else
        sat_exp = 1;
`endif
        s_if.in_valid = 1'b1;
        s_if.in_data  = 16'sd32767;
        tick();
        s_if.in_valid = 1'b0;
        s_if.in_data  = '0;
        for (int i = 0; i < int'(TC); i++) tick();
        chk("sat_valid", 64'(s_if.out_valid), 64'd1);
        chk("sat_data", 64'($signed(s_if.out_data)), sat_exp);
        tick();
        chk("sat_strobe_once", 64'(s_if.out_valid), 64'd0);
        chk("sat_data_hold", 64'($signed(s_if.out_data)), sat_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
